// File: rtl/controle_multiciclo_if.sv
// Control/datapath bundle for the multi-cycle RISC-V controller.
// Latency: none (wires only). Backpressure: mem_ready from the memory stalls the controller.
// master = controller (drives enables/selects/status), slave = datapath/memory side.
interface controle_multiciclo_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       PCSource;
  logic [3:0] estado;
  logic [1:0] erro;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, estado, erro
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, estado, erro
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multi-cycle control FSM for a shared-memory RISC-V datapath (R, I-ALU, lw, sw, beq, jal).
// Latency (mem_ready=1): R/I=4, lw=5, sw=4, beq=3, jal=3 cycles per instruction.
// Backpressure: FETCH/MEM_READ/MEM_WRITE hold until mem_ready; MEM_TIMEOUT waits traps (0 = never).
// Ports: clk, rst_n (async active-low), bus (controle_multiciclo_if.master).
// Optional CTRL_PERF_CNT_EN adds ciclos/instret performance counters (CNT_W bits).
module controle_multiciclo #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  controle_multiciclo_if.master      bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]           ciclos,
  output logic [CNT_W-1:0]           instret
`endif
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  generate
    if (MEM_TIMEOUT < 0 || CNT_W < 1) begin : g_bad_param
      $error("controle_multiciclo: MEM_TIMEOUT must be >= 0 and CNT_W >= 1");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WRITE = 4'd4,
    S_WB_MEM    = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_WB_ALU    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_TRAP      = 4'd15
  } state_t;

  state_t            state, state_next;
  logic [1:0]        erro_q, erro_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_state, timeout_hit;

  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, pc_source;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op;

  assign mem_state   = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  // mem_ready in the limit cycle takes priority: timeout only matters when the access is still pending.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT) && !bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      erro_q   <= ERR_NONE;
      wait_cnt <= '0;
    end else begin
      state  <= state_next;
      erro_q <= erro_next;
      // Any state change clears the counter, so it starts at 0 on entry to every memory state.
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_state && !bus.mem_ready && wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    erro_next  = erro_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_source  = 1'b0;
    mem_to_reg = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          erro_next  = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd2;
        case (bus.opcode)
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next = S_TRAP;
            erro_next  = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        state_next = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_WB_MEM;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          erro_next  = ERR_TIMEOUT;
        end
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_FETCH;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          erro_next  = ERR_TIMEOUT;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = 2'd1;
        alu_op     = 2'b10;
        state_next = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        alu_op     = 2'b10;
        state_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'd1;
        alu_op     = 2'b01;
        pc_source  = 1'b1;
        pc_write   = bus.zero;
        state_next = S_FETCH;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd2;
        pc_write   = 1'b1;
        pc_source  = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_TRAP;  // unreachable encodings park safely
    endcase
  end

  // Enables are masked by rst_n so nothing writes while reset is held, even though FETCH
  // (the reset state) would otherwise request a read and follow mem_ready.
  assign bus.PCWrite  = pc_write  & rst_n;
  assign bus.IRWrite  = ir_write  & rst_n;
  assign bus.MemRead  = mem_read  & rst_n;
  assign bus.MemWrite = mem_write & rst_n;
  assign bus.RegWrite = reg_write & rst_n;
  assign bus.IorD     = iord;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ALUOp    = alu_op;
  assign bus.PCSource = pc_source;
  assign bus.estado   = state;
  assign bus.erro     = erro_q;

`ifdef CTRL_PERF_CNT_EN
  logic retire;
  assign retire = (state_next == S_FETCH) &&
                  ((state == S_WB_MEM) || (state == S_WB_ALU) || (state == S_MEM_WRITE) ||
                   (state == S_BRANCH) || (state == S_JAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ciclos  <= '0;
      instret <= '0;
    end else begin
      if (state != S_TRAP) ciclos  <= ciclos + CNT_W'(1);
      if (retire)          instret <= instret + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Multi-cycle control FSM sequencing a shared-memory RISC-V datapath (single ALU, single instruction/data memory, IR/MDR/A/B/ALUOut registers). It decodes the 7-bit opcode, drives the datapath mux selects and write enables state by state, and waits on a memory ready handshake. Supported opcodes are R-type, I-ALU, lw, sw, beq and jal. Any other opcode, or a memory timeout, traps the core.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles on mem_ready per memory state; 0 disables the timeout.
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  IR[6:0], valid from DECODE onward
zero  input  1  ALU zero flag
mem_ready  input  1  memory completed the current access this cycle
PCWrite  output  1  PC register write enable
IRWrite  output  1  IR write enable
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
RegWrite  output  1  register file write enable
MemtoReg  output  2  writeback select: 0=ALUOut, 1=MDR, 2=PC
ALUSrcA  output  2  ALU A select: 0=PC, 1=regA, 2=oldPC
ALUSrcB  output  2  ALU B select: 0=regB, 1=constant 4, 2=immediate
ALUOp  output  2  ALU operation: 00=add, 01=sub, 10=decode funct
PCSource  output  1  PC source: 0=ALU result, 1=ALUOut
estado  output  4  current state encoding
erro  output  2  error code: 00=none, 01=illegal opcode, 10=memory timeout

Behaviour:
- State register only; all outputs decode from the state. IRWrite, PCWrite and branch PCWrite are additionally gated by mem_ready or zero, as noted below.
- Reset (async, rst_n=0): state=FETCH (0), wait counter=0, erro=00, all enables 0. Selects take FETCH values.
- Any state not listed drives all enables to 0 and all selects to 0.
- States, encodings and outputs:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00, PCSource=0. IRWrite=PCWrite=mem_ready. Goes to DECODE when mem_ready=1.
  - DECODE(1): ALUSrcA=2, ALUSrcB=2, ALUOp=00 (target into ALUOut). Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 and 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other -> TRAP with erro=01
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=2, ALUOp=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ(3): MemRead=1, IorD=1. Goes to WB_MEM on mem_ready.
  - MEM_WRITE(4): MemWrite=1, IorD=1. Goes to FETCH on mem_ready.
  - WB_MEM(5): RegWrite=1, MemtoReg=1. Goes to FETCH.
  - EXEC_R(6): ALUSrcA=1, ALUSrcB=0, ALUOp=10. Goes to WB_ALU.
  - EXEC_I(7): ALUSrcA=1, ALUSrcB=2, ALUOp=10. Goes to WB_ALU.
  - WB_ALU(8): RegWrite=1, MemtoReg=0. Goes to FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCSource=1, PCWrite=zero. Goes to FETCH.
  - JAL(10): RegWrite=1, MemtoReg=2, PCWrite=1, PCSource=1. Goes to FETCH.
  - TRAP(15): all enables 0. Held until reset; erro holds its value.
- Latency with mem_ready tied to 1, in cycles per instruction: R/I=4, lw=5, sw=4, beq=3, jal=3.
- Wait counter:
  - Clears on entry to each of FETCH, MEM_READ and MEM_WRITE; increments every cycle there while mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready=0, the next state is TRAP with erro=10.
  - mem_ready=1 in the same cycle the counter reaches the limit wins: the transition proceeds normally.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Reset mid-instruction aborts immediately; no write enable stays asserted after rst_n falls.

Optional Feature:
CTRL_PERF_CNT_EN.
- Defined: adds output ciclos[CNT_W-1:0] and output instret[CNT_W-1:0], both reset to 0.
  - ciclos increments every cycle the state is not TRAP.
  - instret increments on each transition into FETCH from WB_MEM, WB_ALU, MEM_WRITE, BRANCH or JAL.
  - Both wrap modulo 2^CNT_W.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Reset; mem_ready=1, opcode=0110011 -> estado sequence 0,1,6,8,0. RegWrite=1 only in state 8. PCWrite=IRWrite=1 only in FETCH.
- opcode=0000011; mem_ready low for 3 cycles in MEM_READ -> estado 0,1,2,3,3,3,3,5,0. MemRead=1, IorD=1 throughout state 3.
- opcode=1100011, zero=1 then zero=0 -> PCWrite=1, PCSource=1 in state 9 for the first instruction; PCWrite=0 in state 9 for the second.
- opcode=1101111 -> in state 10: RegWrite=1, MemtoReg=2, PCWrite=1. Returns to 0 on the next cycle.
- opcode=1111111 -> estado 1 then 15, erro=01, held for 10 cycles. rst_n pulse low -> estado=0, erro=00.
- mem_ready=0 for 20 cycles in FETCH with MEM_TIMEOUT=15 -> estado=15, erro=10. With CTRL_PERF_CNT_EN, after 3 add instructions: instret=3, ciclos=12.
